// File: rtl/if_fetch.sv
// ============================================================================
// if_fetch -- instruction-fetch stage
//
// Fetches the 32-bit little-endian instruction at `pc` through the byte-wide
// memory-controller port, one byte per granted request. While the word is
// being assembled it holds the PC by raising if_stall_req. Once all four
// bytes are in, the IF/ID register is loaded on the first edge where ID is
// not stalled. A taken branch from EX (ifjump) abandons the in-flight fetch.
//
// Optional feature macro: ICACHE_EN
//   When defined, a direct-mapped cache of 2**ICACHE_IDX_W words sits in
//   front of the memory port. A hit completes the fetch in one cycle with no
//   memory traffic. A miss refills the entry when the fetch completes.
//   When undefined, there is no storage and every fetch takes the byte path.
//
// Parameters
//   ICACHE_IDX_W  log2 of the cache entry count (used with ICACHE_EN only)
//
// Ports
//   clk           clock
//   rst           asynchronous active-low reset
//   rdy           global ready; low freezes every register and the request
//   stall[5:0]    stall_ctrl vector; stall[1] holds the IF/ID register
//   pc[31:0]      address of the instruction to fetch
//   ifjump        EX branch taken; flushes this stage
//   mem_req       byte read request
//   mem_addr      byte address of the request (pc + bytes issued, wraps)
//   mem_gnt       request accepted this cycle
//   mem_valid     read byte valid (one cycle after each grant)
//   mem_data[7:0] read byte
//   if_stall_req  fetch not complete; hold the PC
//   id_pc         IF/ID instruction address
//   id_inst       IF/ID instruction word
//   id_valid      IF/ID holds a real instruction
// ============================================================================

// ----------------------------------------------------------------------------
// One byte lane of the assembly buffer. A cache fill loads all lanes at once;
// a memory return loads only the lane selected by the receive counter.
// ----------------------------------------------------------------------------
module if_fetch_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_fill,
    input  logic       wr_mem,
    input  logic [7:0] fill_byte,
    input  logic [7:0] mem_byte,
    output logic [7:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= 8'h00;
        else if (wr_fill)
            q <= fill_byte;
        else if (wr_mem)
            q <= mem_byte;
    end
endmodule

// ----------------------------------------------------------------------------
// Fetch stage top
// ----------------------------------------------------------------------------
module if_fetch #(
    parameter int ICACHE_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [5:0]  stall,
    input  logic [31:0] pc,
    input  logic        ifjump,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_valid,
    input  logic [7:0]  mem_data,
    output logic        if_stall_req,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);
    localparam int NUM_LANES = 4;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DONE  = 1'b1
    } state_t;

    state_t                         state;
    logic [2:0]                     issued;    // bytes requested and granted, 0..4
    logic [2:0]                     recv;      // bytes returned, 0..4
    logic [NUM_LANES-1:0][7:0]      buf_q;     // assembly buffer, byte k at lane k

    logic                           in_fetch;
    logic                           active;    // rdy high and no flush this cycle
    logic                           hit;       // cache supplies the word this cycle
    logic [NUM_LANES-1:0][7:0]      fill_word;
    logic                           take_byte; // a returned byte is accepted
    logic                           fill_en;

    // Only stall[1] concerns this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5:2], stall[0]};

    assign in_fetch     = (state == S_FETCH);
    assign active       = rdy & ~ifjump;
    assign if_stall_req = in_fetch;

    // ifjump kills the request combinationally so nothing is issued in the
    // flush cycle; a hit suppresses memory traffic entirely.
    assign mem_req   = in_fetch & (issued < 3'd4) & active & ~hit;
    assign mem_addr  = pc + {29'd0, issued};

    // Bytes landing during a flush are dropped; bytes beyond the fourth
    // cannot occur but are guarded against anyway.
    assign take_byte = active & in_fetch & mem_valid & (recv < 3'd4);
    assign fill_en   = active & hit;

`ifdef ICACHE_EN
    // ------------------------------------------------------------------------
    // Direct-mapped word cache. Valid bits live in resettable flops; tag and
    // data arrays carry no reset so they can map onto RAM.
    // ------------------------------------------------------------------------
    localparam int DEPTH = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    logic [DEPTH-1:0]             c_valid;
    logic [TAG_W-1:0]             c_tag  [DEPTH];
    logic [31:0]                  c_data [DEPTH];

    logic [ICACHE_IDX_W-1:0]      c_idx;
    logic [TAG_W-1:0]             c_tagin;
    logic                         c_wr;
    logic [31:0]                  c_wdata;

    assign c_idx   = pc[ICACHE_IDX_W+1:2];
    assign c_tagin = pc[31:ICACHE_IDX_W+2];

    // Lookup only at the very start of a fetch, before any byte has moved.
    assign hit = in_fetch & (issued == 3'd0) & (recv == 3'd0) &
                 c_valid[c_idx] & (c_tag[c_idx] == c_tagin);
    assign fill_word = c_data[c_idx];

    // Refill on the edge that completes a miss: the fourth byte is still on
    // mem_data, so splice it onto the three already buffered.
    assign c_wr    = take_byte & (recv == 3'd3);
    assign c_wdata = {mem_data, buf_q[2], buf_q[1], buf_q[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            c_valid <= '0;
        else if (c_wr)
            c_valid[c_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (c_wr) begin
            c_tag[c_idx]  <= c_tagin;
            c_data[c_idx] <= c_wdata;
        end
    end
`else
    localparam int unused_idx_w = ICACHE_IDX_W;
    assign hit       = 1'b0;
    assign fill_word = '0;
`endif

    // ------------------------------------------------------------------------
    // Assembly buffer: one lane per byte of the instruction word.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic wr_mem_i;
        assign wr_mem_i = take_byte & (recv[1:0] == 2'(i));

        if_fetch_lane u_lane (
            .clk       (clk),
            .rst       (rst),
            .wr_fill   (fill_en),
            .wr_mem    (wr_mem_i),
            .fill_byte (fill_word[i]),
            .mem_byte  (mem_data),
            .q         (buf_q[i])
        );
    end

    // ------------------------------------------------------------------------
    // Control FSM and IF/ID register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            issued   <= 3'd0;
            recv     <= 3'd0;
            id_pc    <= 32'd0;
            id_inst  <= 32'd0;
            id_valid <= 1'b0;
        end else if (rdy) begin
            if (ifjump) begin
                // Flush wins over everything, including a held ID stage.
                state    <= S_FETCH;
                issued   <= 3'd0;
                recv     <= 3'd0;
                id_valid <= 1'b0;
            end else begin
                case (state)
                    S_FETCH: begin
                        // Nothing ready for ID yet: pass a bubble unless held.
                        if (!stall[1])
                            id_valid <= 1'b0;
                        if (hit) begin
                            state <= S_DONE;
                        end else begin
                            if (mem_req && mem_gnt)
                                issued <= issued + 3'd1;
                            if (take_byte) begin
                                recv <= recv + 3'd1;
                                if (recv == 3'd3)
                                    state <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        // The PC register advances on this same edge, so the
                        // next fetch starts from the new pc next cycle.
                        if (!stall[1]) begin
                            id_pc    <= pc;
                            id_inst  <= buf_q;
                            id_valid <= 1'b1;
                            issued   <= 3'd0;
                            recv     <= 3'd0;
                            state    <= S_FETCH;
                        end
                    end
                    default: state <= S_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ============================================================================
// tb_if_fetch -- self-checking bench for if_fetch.
// A byte-addressed memory image plus a transaction-level model (count grants,
// count returned bytes, look up a word cache) supply every expected value.
// ============================================================================
module tb_if_fetch;
    localparam int IW = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic [31:0] pc = 32'd0;
    logic        ifjump = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic        if_stall_req;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  mem [0:1023];
    logic [31:0] exp_pc = 32'd0;
    logic [31:0] exp_inst = 32'd0;

`ifdef ICACHE_EN
    logic              cval  [0:(1<<IW)-1];
    logic [31:0]       cword [0:(1<<IW)-1];
    logic [29-IW:0]    ctag  [0:(1<<IW)-1];
`endif

    if_fetch #(.ICACHE_IDX_W(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stall        (stall),
        .pc           (pc),
        .ifjump       (ifjump),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data),
        .if_stall_req (if_stall_req),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_valid     (id_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Memory controller: a grant seen before the edge returns its byte in the
    // following cycle.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        g = mem_req & mem_gnt;
        a = mem_addr;
        @(posedge clk);
        #1;
        mem_valid = g;
        mem_data  = g ? mem[a[9:0]] : 8'($urandom);
    endtask

    task automatic cache_clear();
`ifdef ICACHE_EN
        for (int i = 0; i < (1<<IW); i++) cval[i] = 1'b0;
`endif
    endtask

    // One complete fetch from a fresh FETCH state through the IF/ID capture.
    // mode 0: grant always; 1: grant withheld 2 cycles at the third byte;
    // 2: random grant; 3: random grant/ready with ignored jumps;
    // 4: directed ready freeze with a jump inside the frozen window.
    task automatic do_fetch(input logic [31:0] a, input int mode, input int hold);
        int          grants, bytes, c, drops;
        logic        prev_g, hit, r, g, v, done, exp_req;
        logic [31:0] word, ba;
        word = 32'd0;
        for (int k = 0; k < 4; k++) begin
            ba = a + 32'(k);
            word[8*k +: 8] = mem[ba[9:0]];
        end
        hit = 1'b0;
`ifdef ICACHE_EN
        if (cval[a[IW+1:2]] && ctag[a[IW+1:2]] == a[31:IW+2]) begin
            hit  = 1'b1;
            word = cword[a[IW+1:2]];
        end
`endif
        pc = a; stall = 6'd0;
        grants = 0; bytes = 0; c = 0; drops = 0; prev_g = 1'b0; done = 1'b0;
        while (!done) begin
            r = 1'b1; g = 1'b1; ifjump = 1'b0;
            case (mode)
                1: g = !(grants == 2 && drops < 2);
                2: g = ($urandom_range(0, 2) != 0);
                3: begin
                    g = ($urandom_range(0, 2) != 0);
                    r = prev_g ? 1'b1 : ($urandom_range(0, 3) != 0);
                    if (!r) ifjump = 1'($urandom_range(0, 1));
                end
                4: begin
                    g = (c != 1);
                    r = !(c >= 2 && c <= 5);
                    ifjump = (c == 3);
                end
                default: ;
            endcase
            rdy = r; mem_gnt = g;
            #1;
            v = mem_valid;
            exp_req = r && !hit && grants < 4;
            chk("if_stall_req_fetch", {31'd0, if_stall_req}, 32'd1);
            chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
            if (exp_req) chk("mem_addr", mem_addr, a + 32'(grants));
            tick();
            if (r) begin
                if (hit) done = 1'b1;
                else begin
                    if (v) bytes++;
                    if (exp_req && g) grants++;
                    if (!g && exp_req) drops++;
                    if (bytes == 4) done = 1'b1;
                end
            end
            prev_g = exp_req && g;
            c++;
            if (c > 300) begin
                n_chk++; n_fail++;
                $error("FAIL fetch_timeout: observed %0d cycles expected done", c);
                done = 1'b1;
            end
        end
        rdy = 1'b1; ifjump = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            stall = 6'($urandom) & 6'b111101;
            stall[1] = (h < hold);
            mem_gnt = 1'($urandom);
            #1;
            chk("if_stall_req_done", {31'd0, if_stall_req}, 32'd0);
            chk("mem_req_done", {31'd0, mem_req}, 32'd0);
            chk("id_valid_bubble", {31'd0, id_valid}, 32'd0);
            chk("id_pc_hold", id_pc, exp_pc);
            chk("id_inst_hold", id_inst, exp_inst);
            tick();
        end
        stall = 6'd0;
        exp_pc = a; exp_inst = word;
        chk("id_pc", id_pc, exp_pc);
        chk("id_inst", id_inst, exp_inst);
        chk("id_valid", {31'd0, id_valid}, 32'd1);
`ifdef ICACHE_EN
        if (!hit) begin
            cval[a[IW+1:2]]  = 1'b1;
            ctag[a[IW+1:2]]  = a[31:IW+2];
            cword[a[IW+1:2]] = word;
        end
`endif
    endtask

    initial begin
        logic [31:0] rpc;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[32'h300] = 8'h13; mem[32'h301] = 8'h05; mem[32'h302] = 8'h10; mem[32'h303] = 8'h00;
        cache_clear();

        // Reset values
        #2;
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
        chk("rst_if_stall_req", {31'd0, if_stall_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Plain miss, then refetch of the same pc (cache hit when enabled)
        do_fetch(32'h0, 0, 0);
        do_fetch(32'h0, 0, 0);
        chk("refetch_inst", id_inst, 32'h00100513);

        // Grant withheld for two cycles at the third byte
        do_fetch(32'h300, 1, 0);
        chk("grant_stall_inst", id_inst, 32'h00100513);

        // Flush in cycle 2 of a fetch, then redirect to 0x100
        pc = 32'h40; mem_gnt = 1'b1; rdy = 1'b1;
        #1; chk("flush_addr0", mem_addr, 32'h40); tick();
        #1; chk("flush_addr1", mem_addr, 32'h41); tick();
        ifjump = 1'b1;
        #1; chk("flush_mem_req", {31'd0, mem_req}, 32'd0); tick();
        ifjump = 1'b0;
        chk("flush_id_valid", {31'd0, id_valid}, 32'd0);
        do_fetch(32'h100, 0, 0);

        // ID held for three cycles in DONE
        do_fetch(32'h84, 2, 3);

        // Ready frozen for four cycles mid-fetch with an ignored jump
        do_fetch(32'h204, 4, 0);

        // Address wrap at the top of the space
        do_fetch(32'hFFFFFFFE, 0, 1);

        // Randomised fetches; a small pc pool produces repeats
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: rpc = {22'd0, 10'($urandom)};
                1: rpc = {26'd0, 4'($urandom), 2'b00};
                2: rpc = $urandom;
                default: rpc = 32'h0;
            endcase
            do_fetch(rpc, 2 + $urandom_range(0, 1), $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of a fetch
        pc = 32'h10; mem_gnt = 1'b1; rdy = 1'b1;
        #1; tick(); #1; tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_id_pc", id_pc, 32'd0);
        chk("arst_id_inst", id_inst, 32'd0);
        chk("arst_if_stall_req", {31'd0, if_stall_req}, 32'd1);
        rdy = 1'b0; mem_valid = 1'b0; mem_gnt = 1'b0;
        exp_pc = 32'd0; exp_inst = 32'd0;
        cache_clear();
        #2 rst = 1'b1;
        @(posedge clk); #1;
        do_fetch(32'h10, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
